// File: rtl/dcache_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dcache_arbiter
// Purpose  : Shares one D-cache request port between two data masters.
//            Round-robin or fixed-priority arbitration with a starvation guard.
// Revision : 1.0 - initial release
// ============================================================================
module dcache_arbiter #(
    parameter int RR_MODE  = 1,
    parameter int MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_req_valid,
    input  logic        m0_req_rw,
    input  logic [11:0] m0_req_addr,
    input  logic [63:0] m0_data_write,
    output logic [63:0] m0_data_read,
    output logic        m0_ready,
    output logic        m0_hit,
    input  logic        m1_req_valid,
    input  logic        m1_req_rw,
    input  logic [11:0] m1_req_addr,
    input  logic [63:0] m1_data_write,
    output logic [63:0] m1_data_read,
    output logic        m1_ready,
    output logic        m1_hit,
    output logic        dcache_req_valid,
    output logic        dcache_req_rw,
    output logic [11:0] dcache_req_addr,
    output logic [63:0] dcache_data_write,
    input  logic [63:0] dcache_data_read,
    input  logic        dcache_ready,
    input  logic        dcache_hit,
    output logic [1:0]  grant_o
);

    localparam logic [1:0] c_IDLE     = 2'd0;
    localparam logic [1:0] c_BUSY     = 2'd1;
    localparam logic [1:0] c_DONE     = 2'd2;
    localparam logic [3:0] c_MAX_WAIT = 4'(MAX_WAIT);

    logic [1:0]  r_state;
    logic        r_win;
    logic        r_last;
    logic        r_rw;
    logic [11:0] r_addr;
    logic [63:0] r_wdata;
    logic [63:0] r_rdata0;
    logic [63:0] r_rdata1;
    logic [3:0]  r_wait_cnt;

    logic w_any;
    logic w_both;
    logic w_sel;
    logic w_grant_evt;
    logic w_busy;
    logic w_done;

    assign w_any       = m0_req_valid | m1_req_valid;
    assign w_both      = m0_req_valid & m1_req_valid;
    assign w_grant_evt = (r_state == c_IDLE) && w_any;
    assign w_busy      = (r_state == c_BUSY);
    assign w_done      = (r_state == c_DONE);

    // With a lone requester it wins outright; contention goes to the fairness rule.
    assign w_sel = w_both ? ((RR_MODE != 0) ? ~r_last : (r_wait_cnt == c_MAX_WAIT))
                          : m1_req_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= c_IDLE;
            r_win    <= 1'b0;
            r_last   <= 1'b1;
            r_rw     <= 1'b0;
            r_addr   <= 12'd0;
            r_wdata  <= 64'd0;
            r_rdata0 <= 64'd0;
            r_rdata1 <= 64'd0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_any) begin
                        r_win   <= w_sel;
                        r_last  <= w_sel;
                        r_rw    <= w_sel ? m1_req_rw     : m0_req_rw;
                        r_addr  <= w_sel ? m1_req_addr   : m0_req_addr;
                        r_wdata <= w_sel ? m1_data_write : m0_data_write;
                        r_state <= c_BUSY;
                    end
                end
                c_BUSY: begin
                    if (dcache_ready) begin
                        if (!r_rw && !r_win) r_rdata0 <= dcache_data_read;
                        if (!r_rw &&  r_win) r_rdata1 <= dcache_data_read;
                        r_state <= c_DONE;
                    end
                end
                c_DONE:  r_state <= c_IDLE;
                default: r_state <= c_IDLE;
            endcase
        end
    end

    // Counts port-0 wins that port 1 sat through; any port-1 win or idle port 1 clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt <= 4'd0;
        end else if (!m1_req_valid) begin
            r_wait_cnt <= 4'd0;
        end else if (w_grant_evt) begin
            if (w_sel)
                r_wait_cnt <= 4'd0;
            else if (r_wait_cnt != c_MAX_WAIT)
                r_wait_cnt <= r_wait_cnt + 4'd1;
        end
    end

    assign dcache_req_valid  = w_busy;
    assign dcache_req_rw     = r_rw;
    assign dcache_req_addr   = r_addr;
    assign dcache_data_write = r_wdata;

    assign m0_hit       = w_busy & ~r_win & dcache_hit;
    assign m1_hit       = w_busy &  r_win & dcache_hit;
    assign m0_ready     = w_done & ~r_win;
    assign m1_ready     = w_done &  r_win;
    assign m0_data_read = r_rdata0;
    assign m1_data_read = r_rdata1;
    assign grant_o      = (w_busy | w_done) ? {r_win, ~r_win} : 2'b00;

endmodule
`default_nettype wire

// File: tb/tb_dcache_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dcache_arbiter
// Purpose  : Directed self-checking bench; round-robin and fixed-priority
//            instances share one stimulus stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dcache_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_req_valid, m0_req_rw, m1_req_valid, m1_req_rw;
    logic [11:0] m0_req_addr, m1_req_addr;
    logic [63:0] m0_data_write, m1_data_write;
    logic [63:0] dcache_data_read;
    logic        dcache_ready, dcache_hit;

    logic [63:0] a_m0_data_read, a_m1_data_read, b_m0_data_read, b_m1_data_read;
    logic        a_m0_ready, a_m1_ready, a_m0_hit, a_m1_hit;
    logic        b_m0_ready, b_m1_ready, b_m0_hit, b_m1_hit;
    logic        a_req_valid, a_req_rw, b_req_valid, b_req_rw;
    logic [11:0] a_req_addr, b_req_addr;
    logic [63:0] a_data_write, b_data_write;
    logic [1:0]  a_grant, b_grant;

    int checks = 0;
    int errors = 0;

    logic [1:0] exp_rr [6] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
    logic [1:0] exp_fp [6] = '{2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b10};

    always #5 clk = ~clk;

    dcache_arbiter #(.RR_MODE(1), .MAX_WAIT(4)) dut_rr (
        .clk(clk), .rst_n(rst_n),
        .m0_req_valid(m0_req_valid), .m0_req_rw(m0_req_rw), .m0_req_addr(m0_req_addr),
        .m0_data_write(m0_data_write), .m0_data_read(a_m0_data_read),
        .m0_ready(a_m0_ready), .m0_hit(a_m0_hit),
        .m1_req_valid(m1_req_valid), .m1_req_rw(m1_req_rw), .m1_req_addr(m1_req_addr),
        .m1_data_write(m1_data_write), .m1_data_read(a_m1_data_read),
        .m1_ready(a_m1_ready), .m1_hit(a_m1_hit),
        .dcache_req_valid(a_req_valid), .dcache_req_rw(a_req_rw),
        .dcache_req_addr(a_req_addr), .dcache_data_write(a_data_write),
        .dcache_data_read(dcache_data_read), .dcache_ready(dcache_ready),
        .dcache_hit(dcache_hit), .grant_o(a_grant)
    );

    dcache_arbiter #(.RR_MODE(0), .MAX_WAIT(2)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .m0_req_valid(m0_req_valid), .m0_req_rw(m0_req_rw), .m0_req_addr(m0_req_addr),
        .m0_data_write(m0_data_write), .m0_data_read(b_m0_data_read),
        .m0_ready(b_m0_ready), .m0_hit(b_m0_hit),
        .m1_req_valid(m1_req_valid), .m1_req_rw(m1_req_rw), .m1_req_addr(m1_req_addr),
        .m1_data_write(m1_data_write), .m1_data_read(b_m1_data_read),
        .m1_ready(b_m1_ready), .m1_hit(b_m1_hit),
        .dcache_req_valid(b_req_valid), .dcache_req_rw(b_req_rw),
        .dcache_req_addr(b_req_addr), .dcache_data_write(b_data_write),
        .dcache_data_read(dcache_data_read), .dcache_ready(dcache_ready),
        .dcache_hit(dcache_hit), .grant_o(b_grant)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        m0_req_valid = 0; m0_req_rw = 0; m0_req_addr = '0; m0_data_write = '0;
        m1_req_valid = 0; m1_req_rw = 0; m1_req_addr = '0; m1_data_write = '0;
        dcache_data_read = '0; dcache_ready = 0; dcache_hit = 0;
        #12;
        check("rst_req_valid", 64'(a_req_valid), 64'd0);
        check("rst_req_addr",  64'(a_req_addr), 64'd0);
        check("rst_data_write", a_data_write, 64'd0);
        check("rst_grant",     64'(a_grant), 64'd0);
        check("rst_ready",     64'({a_m0_ready, a_m1_ready, a_m0_hit, a_m1_hit}), 64'd0);
        check("rst_rdata",     a_m0_data_read | a_m1_data_read, 64'd0);
        rst_n = 1'b1;
        step;

        // Single read on port 0, cache answers on the third BUSY cycle
        m0_req_valid = 1; m0_req_rw = 0; m0_req_addr = 12'h010;
        step;
        check("rd_valid_c1", 64'(a_req_valid), 64'd1);
        check("rd_addr",     64'(a_req_addr), 64'h010);
        check("rd_grant",    64'(a_grant), 64'b01);
        step;
        check("rd_valid_c2", 64'(a_req_valid), 64'd1);
        step;
        check("rd_valid_c3", 64'(a_req_valid), 64'd1);
        check("rd_no_ready_early", 64'(a_m0_ready), 64'd0);
        dcache_ready = 1; dcache_data_read = 64'hDEAD_BEEF_0123_4567;
        step;
        dcache_ready = 0; m0_req_valid = 0;
        check("rd_valid_done", 64'(a_req_valid), 64'd0);
        check("rd_m0_ready",   64'(a_m0_ready), 64'd1);
        check("rd_m0_data",    a_m0_data_read, 64'hDEAD_BEEF_0123_4567);
        check("rd_m1_quiet",   64'({a_m1_ready, a_m1_hit}), 64'd0);
        check("rd_m1_data",    a_m1_data_read, 64'd0);
        check("rd_grant_done", 64'(a_grant), 64'b01);
        step;
        check("rd_idle_ready", 64'(a_m0_ready), 64'd0);
        check("rd_idle_grant", 64'(a_grant), 64'd0);

        // Write on port 1; requester changes its inputs mid-access
        m1_req_valid = 1; m1_req_rw = 1; m1_req_addr = 12'h3FF;
        m1_data_write = 64'h55AA_55AA_55AA_55AA;
        step;
        dcache_hit = 1;
        #1;
        check("wr_rw",     64'(a_req_rw), 64'd1);
        check("wr_addr",   64'(a_req_addr), 64'h3FF);
        check("wr_grant",  64'(a_grant), 64'b10);
        check("wr_m1_hit", 64'(a_m1_hit), 64'd1);
        check("wr_m0_hit", 64'(a_m0_hit), 64'd0);
        m1_data_write = 64'd0; m1_req_addr = 12'h000;
        step;
        check("wr_data_held", a_data_write, 64'h55AA_55AA_55AA_55AA);
        check("wr_addr_held", 64'(a_req_addr), 64'h3FF);
        dcache_ready = 1; dcache_data_read = 64'h1111_2222_3333_4444;
        step;
        dcache_ready = 0; m1_req_valid = 0; dcache_hit = 0;
        check("wr_m1_ready",  64'(a_m1_ready), 64'd1);
        check("wr_m0_ready",  64'(a_m0_ready), 64'd0);
        check("wr_m1_hit_done", 64'(a_m1_hit), 64'd0);
        check("wr_m1_data",   a_m1_data_read, 64'd0);
        check("wr_m0_data",   a_m0_data_read, 64'hDEAD_BEEF_0123_4567);
        step;
        check("wr_idle_ready", 64'(a_m1_ready), 64'd0);

        // Both ports continuously valid: round-robin vs fixed priority with MAX_WAIT=2
        m0_req_valid = 1; m0_req_rw = 0; m1_req_valid = 1; m1_req_rw = 0;
        for (int i = 0; i < 6; i++) begin
            step;
            check($sformatf("arb_rr_grant%0d", i), 64'(a_grant), 64'(exp_rr[i]));
            check($sformatf("arb_fp_grant%0d", i), 64'(b_grant), 64'(exp_fp[i]));
            dcache_ready = 1; dcache_data_read = 64'(i + 100);
            step;
            dcache_ready = 0;
            check($sformatf("arb_rr_ready%0d", i), 64'({a_m1_ready, a_m0_ready}), 64'(exp_rr[i]));
            check($sformatf("arb_fp_ready%0d", i), 64'({b_m1_ready, b_m0_ready}), 64'(exp_fp[i]));
            step;
        end
        check("arb_rr_m1_data", a_m1_data_read, 64'd105);
        check("arb_fp_m0_data", b_m0_data_read, 64'd104);

        // Asynchronous reset during BUSY discards the access
        m0_req_valid = 0;
        step;
        check("rst_busy_grant", 64'(a_grant), 64'b10);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_valid", 64'({a_req_valid, b_req_valid}), 64'd0);
        check("rst_async_grant", 64'({a_grant, b_grant}), 64'd0);
        check("rst_async_rdata", a_m0_data_read, 64'd0);
        m0_req_valid = 1;
        dcache_ready = 1;
        @(posedge clk);
        #1;
        check("rst_no_ready", 64'({a_m0_ready, a_m1_ready, b_m0_ready, b_m1_ready}), 64'd0);
        dcache_ready = 0;
        #2 rst_n = 1'b1;
        step;
        check("rst_rearb_rr", 64'(a_grant), 64'b01);
        check("rst_rearb_fp", 64'(b_grant), 64'b01);
        dcache_ready = 1; dcache_data_read = 64'hCAFE_F00D_0000_0001;
        step;
        dcache_ready = 0; m0_req_valid = 0; m1_req_valid = 0;
        check("rst_rearb_ready", 64'({a_m1_ready, a_m0_ready}), 64'b01);
        check("rst_rearb_data",  a_m0_data_read, 64'hCAFE_F00D_0000_0001);
        step;

        // Spurious cache completion while idle
        dcache_ready = 1; dcache_data_read = 64'h0BAD_0BAD_0BAD_0BAD;
        step;
        check("spur_ready", 64'({a_m0_ready, a_m1_ready, b_m0_ready, b_m1_ready}), 64'd0);
        check("spur_valid", 64'(a_req_valid), 64'd0);
        check("spur_m0_data", a_m0_data_read, 64'hCAFE_F00D_0000_0001);
        check("spur_m1_data", a_m1_data_read, 64'd0);
        dcache_ready = 0;
        step;
        check("spur_ready_after", 64'({a_m0_ready, a_m1_ready}), 64'd0);
        check("spur_grant_after", 64'(a_grant), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
